// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath width defaults, opcode field location, halt
// opcode and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned INSTR_W_DEF = 16;

    // Opcode field of an instruction word
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and IF/ID. Push and pop may
// happen together when full; flush empties it in one cycle. The head word
// reads as zero while empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage array; no reset needed since the head is gated by count
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the imem req/ack
// handshake, buffers words in fetch_fifo and presents them to IF/ID.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_bubbles counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned          INSTR_W  = INSTR_W_DEF,
    parameter int unsigned          DEPTH    = 2,
    parameter int unsigned          PC_INCR  = 1,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [3:0]           HALT_OP  = HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ifid_valid,
    input  logic               ifid_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic               fetch_halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        stat_fetched,
    output logic [15:0]        stat_bubbles
`endif
);

    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned CA_W    = CNT_W + 1;
    localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

    fetch_state_e       state_q, state_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic               drop_q, drop_d;

    logic               fifo_push, fifo_pop, fifo_flush, fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic [CA_W-1:0]    count_after;
    logic               credit;
    logic               is_halt;

    // Accepted (non-dropped, non-redirected) ack pushes {instr, pc}
    assign fifo_push  = (state_q == BUSY) && imem_ack && !drop_q && !redirect;
    assign fifo_pop   = fifo_valid && ifid_ready;
    assign fifo_flush = redirect;

    // Credit looks at occupancy after this cycle's push/pop; a request that
    // completes this cycle no longer counts as in flight.
    assign count_after = CA_W'(fifo_count) + CA_W'(fifo_push) - CA_W'(fifo_pop);
    assign credit      = (count_after < CA_W'(DEPTH));
    assign pc_inc      = pc_q + INCR;
    assign is_halt     = (opcode_of(imem_data[15:0]) == HALT_OP);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({imem_data, addr_q}),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .valid_o (fifo_valid),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Fetch state, request and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state: redirect overrides everything; an outstanding request that
    // cannot be cancelled is marked for discard instead.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d = redirect_pc;
            if ((state_q == BUSY) && !imem_ack) begin
                drop_d = 1'b1;
            end else begin
                state_d = IDLE;
                req_d   = 1'b0;
                drop_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (credit) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                            if (credit) begin
                                addr_d = pc_q;
                            end else begin
                                req_d   = 1'b0;
                                state_d = IDLE;
                            end
                        end else begin
                            pc_d = pc_inc;
                            if (is_halt) begin
                                req_d   = 1'b0;
                                state_d = HALT;
                            end else if (credit) begin
                                addr_d = pc_inc;
                            end else begin
                                req_d   = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                HALT: begin
                    req_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign ifid_valid   = fifo_valid;
    assign ifid_instr   = fifo_head[ENTRY_W-1:ADDR_W];
    assign ifid_pc      = fifo_head[ADDR_W-1:0];
    assign ifid_pc_next = fifo_valid ? (fifo_head[ADDR_W-1:0] + INCR) : '0;
    assign fetch_halted = (state_q == HALT);

`ifdef FETCH_STATS_EN
    logic [15:0] fetched_q, bubbles_q;

    // Free-running wrap-around counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (fifo_push)                 fetched_q <= fetched_q + 16'd1;
            if (ifid_ready && !fifo_valid) bubbles_q <= bubbles_q + 16'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_bubbles = bubbles_q;
`endif

endmodule
